calc_sequencer: RTL

//  Keypad-driven controller for the 16-bit calculator datapath (operand A/B shift registers, op register, ALU).

---
 rtl/calc_pkg.sv | 19 +
 rtl/calc_sequencer_if.sv | 23 ++
 rtl/calc_sequencer_edge_pulse.sv | 18 +
 rtl/calc_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and key codes for the calculator sequencer and its datapath.
package calc_pkg;

   typedef enum logic [2:0] {S_A, S_B, S_OP, S_WAIT, S_RES} state_t;

   localparam logic [4:0] KEY_CLR = 5'h10;
   localparam logic [4:0] KEY_EXE = 5'h13;

   // Display select: S_WAIT keeps showing the op while the ALU settles.
   function automatic logic [1:0] estado_of(state_t s);
      case (s)
         S_A:     estado_of = 2'd0;
         S_B:     estado_of = 2'd1;
         S_RES:   estado_of = 2'd3;
         default: estado_of = 2'd2;
      endcase
   endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Keypad in / control pulses out between the keypad front end and the sequencer.
interface calc_sequencer_if;
   logic       btnc;
   logic [4:0] val;
   logic       shift_a;
   logic       shift_b;
   logic       load_op;
   logic       capture_res;
   logic       clear;
   logic [1:0] estado;
   logic       busy;
   logic       err;

   modport slave (
      input  btnc, val,
      output shift_a, shift_b, load_op, capture_res, clear, estado, busy, err
   );

   modport master (
      output btnc, val,
      input  shift_a, shift_b, load_op, capture_res, clear, estado, busy, err
   );
endinterface

// File: rtl/calc_sequencer_edge_pulse.sv
// Rising-edge detector; the delayed copy resets to RST_VAL so a level held through reset is not an edge.
module edge_pulse #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic pulse
);
   logic level_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) level_q <= RST_VAL;
      else      level_q <= level;
   end

   assign pulse = level & ~level_q;
endmodule

// File: rtl/calc_sequencer.sv
// Keypad sequencer: turns button presses into one-cycle datapath control pulses.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int DIGITS  = 4,
   parameter int NUM_OPS = 5,
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   calc_sequencer_if.slave   bus
);
   localparam int         CW        = $clog2(DIGITS + 1);
   localparam int         WW        = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [CW-1:0] MAX_DIG = CW'(DIGITS);
   localparam logic [WW-1:0] W_INIT  = WW'(ALU_LAT - 1);
   localparam logic [4:0] NOPS      = 5'(NUM_OPS);

   state_t        state, state_n;
   logic [CW-1:0] dig_cnt, cnt_n;
   logic [WW-1:0] wcnt, wcnt_n;
   logic          op_valid, opv_n;
   logic          press;
   logic          sa_n, sb_n, ld_n, cap_n, clr_n, err_n;
   logic          sa_q, sb_q, ld_q, cap_q, clr_q, err_q, busy_q;
   logic [1:0]    estado_q;
   logic          is_digit, is_clr, is_exe;

   edge_pulse #(.RST_VAL(1'b1)) u_btn (
      .clk   (clk),
      .rst   (rst),
      .level (bus.btnc),
      .pulse (press)
   );

   assign is_digit = ~bus.val[4];
   assign is_clr   = (bus.val == KEY_CLR);
   assign is_exe   = (bus.val == KEY_EXE);

   always_comb begin
      state_n = state;
      cnt_n   = dig_cnt;
      opv_n   = op_valid;
      wcnt_n  = wcnt;
      sa_n    = 1'b0;
      sb_n    = 1'b0;
      ld_n    = 1'b0;
      cap_n   = 1'b0;
      clr_n   = 1'b0;
      err_n   = 1'b0;
      if (press && is_clr) begin
         clr_n   = 1'b1;
         state_n = S_A;
         cnt_n   = '0;
         opv_n   = 1'b0;
         wcnt_n  = '0;
      end else begin
         case (state)
            S_A, S_B: if (press) begin
               if (is_digit) begin
                  if (dig_cnt < MAX_DIG) begin
                     sa_n  = (state == S_A);
                     sb_n  = (state == S_B);
                     cnt_n = dig_cnt + CW'(1);
                  end else begin
                     err_n = 1'b1;
                  end
               end else if (is_exe) begin
                  state_n = (state == S_A) ? S_B : S_OP;
                  cnt_n   = '0;
               end else begin
                  err_n = 1'b1;
               end
            end
            S_OP: if (press) begin
               if (bus.val < NOPS) begin
                  ld_n  = 1'b1;
                  opv_n = 1'b1;
               end else if (is_exe && op_valid) begin
                  state_n = S_WAIT;
                  wcnt_n  = W_INIT;
               end else begin
                  err_n = 1'b1;
               end
            end
            // Presses other than clear are swallowed while the ALU settles.
            S_WAIT: begin
               if (wcnt == '0) begin
                  cap_n   = 1'b1;
                  state_n = S_RES;
               end else begin
                  wcnt_n = wcnt - WW'(1);
               end
            end
            S_RES: if (press) begin
               if (is_exe) begin
                  clr_n   = 1'b1;
                  state_n = S_A;
                  opv_n   = 1'b0;
               end else begin
                  err_n = 1'b1;
               end
            end
            default: state_n = S_A;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_A;
         dig_cnt  <= '0;
         op_valid <= 1'b0;
         wcnt     <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         ld_q     <= 1'b0;
         cap_q    <= 1'b0;
         clr_q    <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         estado_q <= 2'd0;
      end else begin
         state    <= state_n;
         dig_cnt  <= cnt_n;
         op_valid <= opv_n;
         wcnt     <= wcnt_n;
         sa_q     <= sa_n;
         sb_q     <= sb_n;
         ld_q     <= ld_n;
         cap_q    <= cap_n;
         clr_q    <= clr_n;
         err_q    <= err_n;
         busy_q   <= (state_n == S_WAIT);
         estado_q <= estado_of(state_n);
      end
   end

   assign bus.shift_a     = sa_q;
   assign bus.shift_b     = sb_q;
   assign bus.load_op     = ld_q;
   assign bus.capture_res = cap_q;
   assign bus.clear       = clr_q;
   assign bus.err         = err_q;
   assign bus.busy        = busy_q;
   assign bus.estado      = estado_q;
endmodule
